// File: rtl/uart_rx_framer_pkg.sv
// ============================================================================
//  Module      : uart_rx_framer_pkg
//  Description : BobATC uplink word type and receive-FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_rx_framer_pkg;

  localparam int UART_DATA_BITS = 9;

  typedef logic [UART_DATA_BITS-1:0] msg_t;

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;

endpackage

`default_nettype wire

// File: rtl/uart_rx_framer_sync.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer with a selectable reset value.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_framer.sv
// ============================================================================
//  Module      : uart_rx_framer
//  Description : Oversampling UART receiver framing 9-bit BobATC words.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int DIVISOR    = 434,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [8:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       rx_busy
);

  localparam int TIMER_W = $clog2(DIVISOR);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(DIVISOR / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(DIVISOR - 1);
  localparam logic [3:0] LAST_BIT = 4'(UART_DATA_BITS - 1);
  localparam logic ODD_BIT    = (PARITY_ODD != 0);
  localparam logic PAR_EN_BIT = (PARITY_EN != 0);

  logic rxs;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (uart_rx),
    .q       (rxs)
  );

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  msg_t               shift_q, shift_d;
  msg_t               data_q, data_d;
  logic               parity_bad_q, parity_bad_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               perr_q, perr_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TIMER_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    parity_bad_d = parity_bad_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;
    perr_d       = 1'b0;

    case (state_q)
      ST_WAIT_IDLE: begin
        timer_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        timer_d = '0;
        if (!rxs) begin
          state_d      = ST_START;
          parity_bad_d = 1'b0;
        end
      end
      ST_START: begin
        // Half-bit delay aligns every later sample to mid-bit.
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (timer_q == FULL_LAST) begin
          timer_d   = '0;
          shift_d   = {rxs, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == LAST_BIT) state_d = PAR_EN_BIT ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (timer_q == FULL_LAST) begin
          timer_d      = '0;
          parity_bad_d = ((^shift_q) ^ rxs) != ODD_BIT;
          state_d      = ST_STOP;
        end
      end
      ST_STOP: begin
        // A low stop bit dominates: a parity result is meaningless without framing.
        if (timer_q == FULL_LAST) begin
          timer_d = '0;
          if (!rxs) begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end else if (parity_bad_q) begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      parity_bad_q <= 1'b0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      parity_bad_q <= parity_bad_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
    end
  end

  assign uart_rx_data  = data_q;
  assign uart_rx_valid = valid_q;
  assign framing_error = ferr_q;
  assign parity_error  = perr_q;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
// ============================================================================
//  Module      : tb_uart_rx_framer
//  Description : Directed self-checking bench for uart_rx_framer (DIVISOR=16).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_framer;

  localparam int DIV = 16;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [8:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       framing_error;
  logic       parity_error;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int         valid_cnt = 0;
  int         fe_cnt    = 0;
  int         pe_cnt    = 0;
  logic [8:0] words [0:63];

  always #5 clock = ~clock;

  uart_rx_framer #(
    .DIVISOR    (DIV),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .uart_rx       (uart_rx),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .rx_busy       (rx_busy)
  );

  // Record every cycle a pulse is high; a stuck pulse shows up as extra counts.
  always @(negedge clock) begin
    if (uart_rx_valid) begin
      words[valid_cnt[5:0]] <= uart_rx_data;
      valid_cnt <= valid_cnt + 1;
    end
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (parity_error)  pe_cnt <= pe_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic send_frame(input logic [8:0] d, input logic flip_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 9; i++) send_bit(d[i]);
    send_bit((^d) ^ flip_par);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (uart_rx_data !== 9'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", uart_rx_data); end
    checks++; if (uart_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", uart_rx_valid); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", framing_error); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_error); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", rx_busy); end
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", rx_busy); end
  endtask

  task automatic test_good_frame;
    int v0, f0, p0;
    v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
    send_frame(9'h1A5, 1'b0, 1'b1);
    idle(6);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL good_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (words[v0[5:0]] !== 9'h1A5) begin errors++; $display("FAIL good_word: got %h expected 1a5", words[v0[5:0]]); end
    checks++; if (uart_rx_data !== 9'h1A5) begin errors++; $display("FAIL good_data_hold: got %h expected 1a5", uart_rx_data); end
    checks++; if (fe_cnt != f0 || pe_cnt != p0) begin errors++; $display("FAIL good_no_error: got fe %0d pe %0d expected 0 0", fe_cnt - f0, pe_cnt - p0); end
  endtask

  task automatic test_glitch;
    int v0, f0, p0;
    logic done;
    v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b expected 1", rx_busy); end
    uart_rx = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clock);
      if (!rx_busy) done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL glitch_return_idle: got busy %b expected 0 within 10 cycles", rx_busy); end
    idle(20);
    checks++; if (valid_cnt != v0 || fe_cnt != f0 || pe_cnt != p0) begin
      errors++; $display("FAIL glitch_no_pulse: got v %0d fe %0d pe %0d expected 0 0 0", valid_cnt - v0, fe_cnt - f0, pe_cnt - p0);
    end
  endtask

  task automatic test_framing;
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(9'h0F3, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (100) @(negedge clock);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL framing_pulse: got %0d expected 1", fe_cnt - f0); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL framing_no_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL framing_wait_idle: busy got %b expected 1", rx_busy); end
    idle(20);
    send_frame(9'h001, 1'b0, 1'b1);
    idle(6);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL recover_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (uart_rx_data !== 9'h001) begin errors++; $display("FAIL recover_data: got %h expected 001", uart_rx_data); end
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL recover_no_new_ferr: got %0d expected 1", fe_cnt - f0); end
  endtask

  task automatic test_parity;
    int v0, f0, p0;
    v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
    send_frame(9'h155, 1'b1, 1'b1);
    idle(6);
    checks++; if (pe_cnt - p0 !== 1) begin errors++; $display("FAIL parity_pulse: got %0d expected 1", pe_cnt - p0); end
    checks++; if (valid_cnt != v0 || fe_cnt != f0) begin errors++; $display("FAIL parity_only: got v %0d fe %0d expected 0 0", valid_cnt - v0, fe_cnt - f0); end
    checks++; if (uart_rx_data !== 9'h001) begin errors++; $display("FAIL parity_data_kept: got %h expected 001", uart_rx_data); end
  endtask

  task automatic test_back_to_back;
    int v0, f0, p0;
    v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
    send_frame(9'h0AA, 1'b0, 1'b1);
    send_frame(9'h1FF, 1'b0, 1'b1);
    idle(6);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - v0); end
    checks++; if (words[v0[5:0]] !== 9'h0AA) begin errors++; $display("FAIL b2b_first: got %h expected 0aa", words[v0[5:0]]); end
    checks++; if (words[6'(v0 + 1)] !== 9'h1FF) begin errors++; $display("FAIL b2b_second: got %h expected 1ff", words[6'(v0 + 1)]); end
    checks++; if (fe_cnt != f0 || pe_cnt != p0) begin errors++; $display("FAIL b2b_no_error: got fe %0d pe %0d expected 0 0", fe_cnt - f0, pe_cnt - p0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, p0;
    logic [8:0] d;
    d = 9'h1C3;
    v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    // Reset late in bit 5 so the restarted receiver cannot lock onto this bit.
    uart_rx = d[5];
    repeat (13) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 6; i < 9; i++) send_bit(d[i]);
    send_bit(^d);
    send_bit(1'b1);
    idle(40);
    checks++; if (valid_cnt != v0 || fe_cnt != f0 || pe_cnt != p0) begin
      errors++; $display("FAIL midreset_no_pulse: got v %0d fe %0d pe %0d expected 0 0 0", valid_cnt - v0, fe_cnt - f0, pe_cnt - p0);
    end
    checks++; if (uart_rx_data !== 9'h000) begin errors++; $display("FAIL midreset_data_cleared: got %h expected 000", uart_rx_data); end
    send_frame(9'h03C, 1'b0, 1'b1);
    idle(6);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midreset_next_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (uart_rx_data !== 9'h03C) begin errors++; $display("FAIL midreset_next_data: got %h expected 03c", uart_rx_data); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
